// File: rtl/bfs_engine_param.sv
// Breadth-first traversal engine over a CSR graph held in external memory.
// One read outstanding at a time; visited bitmap, distance table and a
// circular node queue are kept on-chip and sized by NUM_NODES.
module bfs_engine_param #(
    parameter int          NUM_NODES = 64,
    parameter int          NODE_W    = 6,
    parameter int          DIST_W    = 8,
    parameter logic [31:0] ROW_BASE  = 32'h0000_0000,
    parameter logic [31:0] COL_BASE  = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       start_node_id,
    input  logic [DIST_W-1:0] max_depth,
    output logic              done,
    output logic              busy,
    output logic              err_range,
    output logic [31:0]       mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_data,
    input  logic              mem_valid,
    input  logic [NODE_W-1:0] rd_node,
    output logic [DIST_W-1:0] rd_dist,
    output logic [31:0]       nodes_visited_count,
    output logic [31:0]       edges_scanned_count,
    output logic [DIST_W-1:0] current_level,
    output logic [31:0]       current_node,
    output logic [31:0]       last_discovered_node,
    output logic              node_discovered_pulse
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_DEQ, S_RD_ROW0, S_RD_ROW1, S_RD_COL, S_CHECK, S_DONE
    } state_t;

    localparam logic [DIST_W-1:0] DIST_INF   = '1;
    localparam logic [DIST_W-1:0] DIST_MAX   = {{(DIST_W-1){1'b1}}, 1'b0};
    localparam logic [31:0]       NODE_LIMIT = 32'(NUM_NODES);

    state_t              r_state;
    logic [NUM_NODES-1:0] r_visited;
    logic [DIST_W-1:0]   r_dist [NUM_NODES];
    logic [NODE_W-1:0]   r_queue [NUM_NODES];
    logic [NODE_W-1:0]   r_head;
    logic [NODE_W-1:0]   r_tail;
    logic [NODE_W:0]     r_q_count;
    logic [31:0]         r_start_node;
    logic [31:0]         r_begin;
    logic [31:0]         r_end;
    logic [31:0]         r_edge;
    logic [31:0]         r_nbr;
    logic                r_pending;

    logic                w_abort;
    logic                w_valid;
    logic                w_start_ok;
    logic                w_nbr_in_range;
    logic [NODE_W-1:0]   w_nbr_idx;
    logic                w_depth_ok;
    logic [DIST_W-1:0]   w_next_dist;
    logic                w_discover;
    logic                w_enq;
    logic [NODE_W-1:0]   w_enq_node;
    logic [NODE_W-1:0]   w_pop_node;
    logic [31:0]         w_next_edge;

    assign rd_dist = r_dist[rd_node];

    // Decode of the current edge and queue/handshake qualifiers
    always_comb begin
        // NOTE: combinational logic uses blocking assignments with a default
        // for every signal first, so no path can leave a value held (latch).
        w_abort        = abort && (r_state != S_IDLE);
        w_valid        = mem_valid && r_pending;
        w_start_ok     = r_start_node < NODE_LIMIT;
        w_nbr_in_range = r_nbr < NODE_LIMIT;
        w_nbr_idx      = r_nbr[NODE_W-1:0];
        w_depth_ok     = (max_depth == '0) ||
                         (({1'b0, current_level} + (DIST_W+1)'(1)) <= {1'b0, max_depth});
        w_next_dist    = (current_level >= DIST_MAX) ? DIST_MAX : current_level + DIST_W'(1);
        w_discover     = (r_state == S_CHECK) && !w_abort && w_nbr_in_range &&
                         !r_visited[w_nbr_idx] && w_depth_ok;
        w_enq          = ((r_state == S_INIT) && !w_abort && w_start_ok) || w_discover;
        w_enq_node     = (r_state == S_INIT) ? r_start_node[NODE_W-1:0] : w_nbr_idx;
        w_pop_node     = r_queue[r_head];
        w_next_edge    = r_edge + 32'd1;
    end

    // Queue storage, written at the tail on every enqueue
    always_ff @(posedge clk) begin
        // NOTE: the queue array is deliberately not reset; head/tail/count
        // define which entries are meaningful, so stale contents are harmless.
        if (w_enq) begin
            r_queue[r_tail] <= w_enq_node;
        end
    end

    // Traversal FSM with registered outputs, bitmap, distances and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state               <= S_IDLE;
            r_visited             <= '0;
            for (int i = 0; i < NUM_NODES; i++) r_dist[i] <= DIST_INF;
            r_head                <= '0;
            r_tail                <= '0;
            r_q_count             <= '0;
            r_start_node          <= '0;
            r_begin               <= '0;
            r_end                 <= '0;
            r_edge                <= '0;
            r_nbr                 <= '0;
            r_pending             <= 1'b0;
            done                  <= 1'b0;
            busy                  <= 1'b0;
            err_range             <= 1'b0;
            mem_addr              <= '0;
            mem_rd_en             <= 1'b0;
            nodes_visited_count   <= '0;
            edges_scanned_count   <= '0;
            current_level         <= '0;
            current_node          <= '0;
            last_discovered_node  <= '0;
            node_discovered_pulse <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            mem_rd_en             <= 1'b0;
            node_discovered_pulse <= 1'b0;
            if (w_abort) begin
                r_state   <= S_DONE;
                r_pending <= 1'b0;
                done      <= 1'b1;
                busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            r_state             <= S_INIT;
                            busy                <= 1'b1;
                            done                <= 1'b0;
                            err_range           <= 1'b0;
                            nodes_visited_count <= '0;
                            edges_scanned_count <= '0;
                            r_visited           <= '0;
                            for (int i = 0; i < NUM_NODES; i++) r_dist[i] <= DIST_INF;
                            r_head              <= '0;
                            r_tail              <= '0;
                            r_q_count           <= '0;
                            r_pending           <= 1'b0;
                            r_start_node        <= start_node_id;
                        end
                    end
                    S_INIT: begin
                        if (!w_start_ok) begin
                            err_range           <= 1'b1;
                            nodes_visited_count <= '0;
                            r_state             <= S_DONE;
                            done                <= 1'b1;
                            busy                <= 1'b0;
                        end else begin
                            r_visited[r_start_node[NODE_W-1:0]] <= 1'b1;
                            r_dist[r_start_node[NODE_W-1:0]]    <= '0;
                            r_tail              <= r_tail + NODE_W'(1);
                            r_q_count           <= r_q_count + (NODE_W+1)'(1);
                            nodes_visited_count <= 32'd1;
                            r_state             <= S_DEQ;
                        end
                    end
                    S_DEQ: begin
                        if (r_q_count == '0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            current_node  <= 32'(w_pop_node);
                            current_level <= r_dist[w_pop_node];
                            r_head        <= r_head + NODE_W'(1);
                            r_q_count     <= r_q_count - (NODE_W+1)'(1);
                            mem_addr      <= ROW_BASE + (32'(w_pop_node) << 2);
                            mem_rd_en     <= 1'b1;
                            r_pending     <= 1'b1;
                            r_state       <= S_RD_ROW0;
                        end
                    end
                    S_RD_ROW0: begin
                        if (w_valid) begin
                            r_begin   <= mem_data;
                            mem_addr  <= ROW_BASE + ((current_node + 32'd1) << 2);
                            mem_rd_en <= 1'b1;
                            r_state   <= S_RD_ROW1;
                        end
                    end
                    S_RD_ROW1: begin
                        if (w_valid) begin
                            r_end <= mem_data;
                            if (mem_data <= r_begin) begin
                                r_pending <= 1'b0;
                                r_state   <= S_DEQ;
                            end else begin
                                r_edge    <= r_begin;
                                mem_addr  <= COL_BASE + (r_begin << 2);
                                mem_rd_en <= 1'b1;
                                r_state   <= S_RD_COL;
                            end
                        end
                    end
                    S_RD_COL: begin
                        if (w_valid) begin
                            r_nbr     <= mem_data;
                            r_pending <= 1'b0;
                            r_state   <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        edges_scanned_count <= edges_scanned_count + 32'd1;
                        if (!w_nbr_in_range) begin
                            err_range <= 1'b1;
                        end else if (w_discover) begin
                            r_visited[w_nbr_idx]  <= 1'b1;
                            r_dist[w_nbr_idx]     <= w_next_dist;
                            r_tail                <= r_tail + NODE_W'(1);
                            r_q_count             <= r_q_count + (NODE_W+1)'(1);
                            nodes_visited_count   <= nodes_visited_count + 32'd1;
                            node_discovered_pulse <= 1'b1;
                            last_discovered_node  <= r_nbr;
                        end
                        r_edge <= w_next_edge;
                        if (w_next_edge < r_end) begin
                            mem_addr  <= COL_BASE + (w_next_edge << 2);
                            mem_rd_en <= 1'b1;
                            r_pending <= 1'b1;
                            r_state   <= S_RD_COL;
                        end else begin
                            r_state <= S_DEQ;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/bfs_engine_param.md
BFS_ENGINE_PARAM -- requirements
Module: bfs_engine_param

Interface
REQ-001 Parameters SHALL be: NUM_NODES, default 64, node count (power of 2, 4..1024); NODE_W, default 6, log2(NUM_NODES); DIST_W, default 8, distance width; ROW_BASE, default 32'h0000_0000, byte base of row-pointer array; COL_BASE, default 32'h0000_1000, byte base of column array.
REQ-002 Ports SHALL be, in order (name direction width meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin traversal; sampled only in IDLE or DONE.
- abort  in  1  terminate current traversal.
- start_node_id  in  32  source node.
- max_depth  in  DIST_W  deepest level to enqueue; 0 = unlimited.
- done  out  1  traversal finished; level, held until next start.
- busy  out  1  traversal in progress.
- err_range  out  1  sticky: start node or a neighbour ID >= NUM_NODES was seen.
- mem_addr  out  32  byte read address.
- mem_rd_en  out  1  one-cycle read request.
- mem_data  in  32  read data.
- mem_valid  in  1  read data valid.
- rd_node  in  NODE_W  distance readback index.
- rd_dist  out  DIST_W  distance of rd_node, combinational; all-ones = unreached.
- nodes_visited_count, edges_scanned_count  out  32 each  statistics.
- current_level  out  DIST_W  level of the node being expanded.
- current_node  out  32  node being expanded.
- last_discovered_node  out  32  most recent newly visited node.
- node_discovered_pulse  out  1  one-cycle pulse per discovery.

Function
REQ-003 Graph SHALL be CSR: edges of node n are column words row[n]..row[n+1]-1; row[k] is at ROW_BASE+4k and column word j is at COL_BASE+4j.
REQ-004 At most one read SHALL be outstanding; mem_rd_en pulses exactly one cycle, mem_addr stays stable until mem_valid, and mem_valid arriving with no request outstanding is ignored.
REQ-005 States SHALL be IDLE, INIT, DEQ, RD_ROW0, RD_ROW1, RD_COL, CHECK, DONE.
REQ-006 IDLE/DONE + start: go to INIT, busy=1, done=0; counters, err_range, visited bitmap and distances cleared to 0/0/0/all-ones.
REQ-007 INIT: if start_node_id >= NUM_NODES, set err_range, nodes_visited_count=0, go to DONE; otherwise mark visited, dist=0, enqueue, nodes_visited_count=1, go to DEQ.
REQ-008 DEQ: queue empty -> DONE; otherwise pop to current_node, current_level=dist[node], issue row[n] read -> RD_ROW0.
REQ-009 RD_ROW0 on valid: latch begin, issue row[n+1] read -> RD_ROW1. RD_ROW1 on valid: latch end; if end <= begin go to DEQ, else issue column read at begin -> RD_COL.
REQ-010 RD_COL on valid: latch neighbour -> CHECK; CHECK increments edges_scanned_count by 1 per edge.
REQ-011 CHECK: if neighbour >= NUM_NODES, set err_range and skip the edge (counted, not visited); else if unvisited and (max_depth==0 or current_level+1 <= max_depth), mark visited, dist=current_level+1, enqueue, nodes_visited_count+1, pulse node_discovered_pulse, update last_discovered_node.
REQ-012 CHECK, a node at depth limit: the edge SHALL be counted but the neighbour not marked, so it remains unreached (all-ones).
REQ-013 After CHECK: if more edges remain, read next column word -> RD_COL; else -> DEQ.
REQ-014 Queue SHALL be a NUM_NODES-deep circular FIFO with NODE_W-bit pointers wrapping modulo NUM_NODES; each node is enqueued at most once, so it never overflows.
REQ-015 Distance arithmetic SHALL saturate at all-ones minus 1; all-ones is reserved for unreached.
REQ-016 abort in any non-IDLE state SHALL go to DONE the next cycle (done=1, busy=0) with statistics frozen; a late mem_valid is dropped. abort takes priority over start.
REQ-017 DONE: done=1, busy=0; rd_dist remains readable until the next start.

Reset
REQ-018 rst_n low SHALL asynchronously force state IDLE; all outputs 0 except rd_dist = all-ones; bitmap cleared; distances all-ones; queue pointers 0. Reset mid-traversal discards all progress.

Verification
REQ-019 Path 0-1-2-3, start 0 -> visited 4, edges 3, rd_dist(3)=3, done=1.
REQ-020 Star: node 0 with 5 leaves, max_depth=0 -> visited 6, 5 discovery pulses in edge order; 0 edges from each leaf.
REQ-021 Same path, max_depth=1 -> visited 2, rd_dist(2)=all-ones, edges 2.
REQ-022 Neighbour ID 200 with NUM_NODES=64 -> err_range=1, edge counted, traversal completes normally. Start node 64 -> done, visited 0, err_range=1.
REQ-023 abort during RD_COL with mem_valid delayed 5 cycles -> done next cycle, counters frozen, no further mem_rd_en.
REQ-024 rst_n low mid-traversal, then start again -> identical results to a clean run; NUM_NODES=16 full-ring graph exercises queue pointer wrap.
